// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches 16-bit words from a registered ROM,
// decodes them and drives register-file, ALU and data-memory controls.
module control_unit (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [15:0] IR_data,
   output logic [6:0]  PC_addr,
   output logic        IR_rd,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        MuxSel,
   output logic [3:0]  RF_W_Addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_A_addr,
   output logic [3:0]  RF_B_addr,
   output logic [2:0]  ALU_s,
   output logic        Halted,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD_A = 4'd3,
      S_LOAD_B = 4'd4,
      S_STORE  = 4'd5,
      S_ADD    = 4'd6,
      S_SUB    = 4'd7,
      S_NOOP   = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_pc;
   // Only the operand fields are kept; the opcode is consumed while in DECODE.
   logic [11:0] r_ir;
   logic [3:0]  w_opcode;

   assign w_opcode = IR_data[15:12];
   assign PC_addr  = r_pc;
   assign State    = r_state;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= S_INIT;
         r_pc    <= 7'd0;
         r_ir    <= 12'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_FETCH) begin
            r_pc <= r_pc + 7'd1;
         end
         if (r_state == S_DECODE) begin
            r_ir <= IR_data[11:0];
         end
      end
   end

   // NOTE: every output and the next state get a default before the case, so
   // no path through the block leaves a variable unassigned (no latches).
   always_comb begin
      w_next    = r_state;
      IR_rd     = 1'b0;
      D_addr    = 8'd0;
      D_wr      = 1'b0;
      MuxSel    = 1'b0;
      RF_W_Addr = 4'd0;
      RF_W_en   = 1'b0;
      RF_A_addr = 4'd0;
      RF_B_addr = 4'd0;
      ALU_s     = ALU_PASS;
      Halted    = 1'b0;

      case (r_state)
         S_INIT: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            IR_rd  = 1'b1;
            w_next = S_DECODE;
         end
         S_DECODE: begin
            case (w_opcode)
               4'h1:    w_next = S_LOAD_A;
               4'h2:    w_next = S_STORE;
               4'h3:    w_next = S_ADD;
               4'h4:    w_next = S_SUB;
               4'h5:    w_next = S_HALT;
               default: w_next = S_NOOP;
            endcase
         end
         S_LOAD_A: begin
            D_addr    = r_ir[11:4];
            RF_W_Addr = r_ir[3:0];
            MuxSel    = 1'b1;
            w_next    = S_LOAD_B;
         end
         // Second LOAD cycle: memory read data is now valid, commit it.
         S_LOAD_B: begin
            D_addr    = r_ir[11:4];
            RF_W_Addr = r_ir[3:0];
            MuxSel    = 1'b1;
            RF_W_en   = 1'b1;
            w_next    = S_FETCH;
         end
         S_STORE: begin
            RF_A_addr = r_ir[11:8];
            D_addr    = r_ir[7:0];
            D_wr      = 1'b1;
            w_next    = S_FETCH;
         end
         S_ADD, S_SUB: begin
            RF_A_addr = r_ir[11:8];
            RF_B_addr = r_ir[7:4];
            RF_W_Addr = r_ir[3:0];
            ALU_s     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            RF_W_en   = 1'b1;
            w_next    = S_FETCH;
         end
         S_NOOP: begin
            w_next = S_FETCH;
         end
         S_HALT: begin
            Halted = 1'b1;
            w_next = S_HALT;
         end
         default: begin
            w_next = S_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a registered ROM model feeds instructions, and
// per-cycle expected outputs go through a scoreboard queue before comparison.
module tb_control_unit;

   localparam logic [3:0] ST_INIT   = 4'd0;
   localparam logic [3:0] ST_FETCH  = 4'd1;
   localparam logic [3:0] ST_DECODE = 4'd2;
   localparam logic [3:0] ST_LOAD_A = 4'd3;
   localparam logic [3:0] ST_LOAD_B = 4'd4;
   localparam logic [3:0] ST_STORE  = 4'd5;
   localparam logic [3:0] ST_ADD    = 4'd6;
   localparam logic [3:0] ST_SUB    = 4'd7;
   localparam logic [3:0] ST_NOOP   = 4'd8;
   localparam logic [3:0] ST_HALT   = 4'd9;

   logic        CLK;
   logic        Reset;
   logic [15:0] IR_data;
   logic [6:0]  PC_addr;
   logic        IR_rd;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic        MuxSel;
   logic [3:0]  RF_W_Addr;
   logic        RF_W_en;
   logic [3:0]  RF_A_addr;
   logic [3:0]  RF_B_addr;
   logic [2:0]  ALU_s;
   logic        Halted;
   logic [3:0]  State;

   typedef struct {
      logic [3:0] state;
      logic [6:0] pc;
      logic       ir_rd;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       mux;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] a_addr;
      logic [3:0] b_addr;
      logic [2:0] alu;
      logic       halted;
   } vec_t;

   vec_t        sb_q[$];
   int          n_vectors     = 0;
   int          n_miscompares = 0;
   logic [15:0] rom [0:127];

   control_unit dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .IR_data   (IR_data),
      .PC_addr   (PC_addr),
      .IR_rd     (IR_rd),
      .D_addr    (D_addr),
      .D_wr      (D_wr),
      .MuxSel    (MuxSel),
      .RF_W_Addr (RF_W_Addr),
      .RF_W_en   (RF_W_en),
      .RF_A_addr (RF_A_addr),
      .RF_B_addr (RF_B_addr),
      .ALU_s     (ALU_s),
      .Halted    (Halted),
      .State     (State)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Instruction ROM with a registered read port.
   initial IR_data = 16'd0;
   always @(posedge CLK) begin
      if (IR_rd) IR_data <= rom[PC_addr];
   end

   // Memory write and register write must never coincide.
   always @(negedge CLK) begin
      assert (!(D_wr === 1'b1 && RF_W_en === 1'b1)) else begin
         n_miscompares++;
         $error("FAIL wr_excl observed D_wr=%b RF_W_en=%b expected not both 1", D_wr, RF_W_en);
      end
   end

   // Expected outputs for a state, instruction word and PC value.
   function automatic vec_t model(input logic [3:0] st, input logic [15:0] ir,
                                  input logic [6:0] pc);
      vec_t v;
      v.state  = st;
      v.pc     = pc;
      v.ir_rd  = 1'b0;
      v.d_addr = 8'd0;
      v.d_wr   = 1'b0;
      v.mux    = 1'b0;
      v.w_addr = 4'd0;
      v.w_en   = 1'b0;
      v.a_addr = 4'd0;
      v.b_addr = 4'd0;
      v.alu    = 3'b000;
      v.halted = 1'b0;
      case (st)
         ST_FETCH: v.ir_rd = 1'b1;
         ST_LOAD_A, ST_LOAD_B: begin
            v.d_addr = ir[11:4];
            v.w_addr = ir[3:0];
            v.mux    = 1'b1;
            v.w_en   = (st == ST_LOAD_B);
         end
         ST_STORE: begin
            v.a_addr = ir[11:8];
            v.d_addr = ir[7:0];
            v.d_wr   = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            v.a_addr = ir[11:8];
            v.b_addr = ir[7:4];
            v.w_addr = ir[3:0];
            v.alu    = (st == ST_ADD) ? 3'b001 : 3'b010;
            v.w_en   = 1'b1;
         end
         ST_HALT: v.halted = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      assert (obs === exp) else begin
         n_miscompares++;
         $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_front();
      vec_t e;
      e = sb_q.pop_front();
      n_vectors++;
      cmp("State",     {12'd0, State},     {12'd0, e.state});
      cmp("PC_addr",   {9'd0, PC_addr},    {9'd0, e.pc});
      cmp("IR_rd",     {15'd0, IR_rd},     {15'd0, e.ir_rd});
      cmp("D_addr",    {8'd0, D_addr},     {8'd0, e.d_addr});
      cmp("D_wr",      {15'd0, D_wr},      {15'd0, e.d_wr});
      cmp("MuxSel",    {15'd0, MuxSel},    {15'd0, e.mux});
      cmp("RF_W_Addr", {12'd0, RF_W_Addr}, {12'd0, e.w_addr});
      cmp("RF_W_en",   {15'd0, RF_W_en},   {15'd0, e.w_en});
      cmp("RF_A_addr", {12'd0, RF_A_addr}, {12'd0, e.a_addr});
      cmp("RF_B_addr", {12'd0, RF_B_addr}, {12'd0, e.b_addr});
      cmp("ALU_s",     {13'd0, ALU_s},     {13'd0, e.alu});
      cmp("Halted",    {15'd0, Halted},    {15'd0, e.halted});
   endtask

   // Push the expectation, advance one clock, then compare away from the edge.
   task automatic step(input logic [3:0] st, input logic [15:0] ir, input logic [6:0] pc);
      sb_q.push_back(model(st, ir, pc));
      @(posedge CLK);
      #1;
      check_front();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(ST_INIT, 16'h0000, 7'd0);
      step(ST_INIT, 16'h0000, 7'd0);
      Reset = 1'b0;
   endtask

   initial begin
      logic [6:0]  pc;
      logic [6:0]  pn;
      logic [3:0]  op;
      int          r;

      Reset = 1'b1;
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

      // ADD r3 = r1 + r2
      rom[0] = 16'h3123;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_ADD,    16'h3123, 7'd1);
      cmp("add_rfa_lit", {12'd0, RF_A_addr}, 16'd1);
      cmp("add_rfb_lit", {12'd0, RF_B_addr}, 16'd2);
      cmp("add_rfw_lit", {12'd0, RF_W_Addr}, 16'd3);
      cmp("add_alu_lit", {13'd0, ALU_s},     16'd1);
      step(ST_FETCH,  16'h0000, 7'd1);

      // LOAD r5 <- mem[0x1A], four cycles fetch-to-fetch
      rom[0] = 16'h11A5;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_LOAD_A, 16'h11A5, 7'd1);
      step(ST_LOAD_B, 16'h11A5, 7'd1);
      cmp("load_daddr_lit", {8'd0, D_addr}, 16'h001A);
      step(ST_FETCH,  16'h0000, 7'd1);

      // STORE r7 -> mem[0x40]
      rom[0] = 16'h2740;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_STORE,  16'h2740, 7'd1);
      step(ST_FETCH,  16'h0000, 7'd1);

      // SUB r9 = rC - rD
      rom[0] = 16'h4CD9;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_SUB,    16'h4CD9, 7'd1);
      step(ST_FETCH,  16'h0000, 7'd1);

      // Undefined opcode as NOOP, then HALT holds with PC frozen until reset
      rom[0] = 16'hF000;
      rom[1] = 16'h5000;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_NOOP,   16'hF000, 7'd1);
      step(ST_FETCH,  16'h0000, 7'd1);
      step(ST_DECODE, 16'h0000, 7'd2);
      for (int i = 0; i < 20; i++) step(ST_HALT, 16'h5000, 7'd2);
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);

      // 128 NOOP-class instructions: PC wraps 127 -> 0
      for (int i = 0; i < 128; i++) begin
         r  = $urandom_range(0, 10);
         op = (r == 10) ? 4'h0 : 4'(r + 6);
         rom[i] = {op, 12'($urandom)};
      end
      do_reset();
      for (int i = 0; i < 128; i++) begin
         pc = 7'(i);
         pn = pc + 7'd1;
         step(ST_FETCH,  16'h0000, pc);
         step(ST_DECODE, 16'h0000, pn);
         step(ST_NOOP,   rom[pc],  pn);
      end
      step(ST_FETCH, 16'h0000, 7'd0);

      // Reset in the middle of a LOAD: no register write may escape
      rom[0] = 16'h11A5;
      do_reset();
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_LOAD_A, 16'h11A5, 7'd1);
      Reset = 1'b1;
      step(ST_INIT,   16'h0000, 7'd0);
      Reset = 1'b0;
      step(ST_FETCH,  16'h0000, 7'd0);
      step(ST_DECODE, 16'h0000, 7'd1);
      step(ST_LOAD_A, 16'h11A5, 7'd1);
      step(ST_LOAD_B, 16'h11A5, 7'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL expose: CLK  input  1  system clock, all state updated on rising edge.
REQ-002 The block SHALL expose: Reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 The block SHALL expose: IR_data  input  16  instruction word from instruction ROM, registered read, valid one cycle after PC_addr is presented with IR_rd=1.
REQ-004 The block SHALL expose: PC_addr  output  7  instruction ROM address, equal to the PC register.
REQ-005 The block SHALL expose: IR_rd  output  1  instruction ROM read enable.
REQ-006 The block SHALL expose datapath controls, all outputs: D_addr 8, D_wr 1, MuxSel 1, RF_W_Addr 4, RF_W_en 1, RF_A_addr 4, RF_B_addr 4, ALU_s 3 -- meanings as consumed by the datapath (MuxSel=1 selects data-memory read data, 0 selects ALU result; STORE writes RF port A data to memory).
REQ-007 The block SHALL expose: Halted  output  1  high while in HALT; State  output  4  current state code for debug.

Function
REQ-008 Instruction format SHALL be opcode IR[15:12]: 0000 NOOP; 0001 LOAD (D_addr=IR[11:4], Rd=IR[3:0]); 0010 STORE (Ra=IR[11:8], D_addr=IR[7:0]); 0011 ADD and 0100 SUB (Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]); 0101 HALT; 0110-1111 SHALL execute as NOOP.
REQ-009 ALU_s codes SHALL be 3'b001 for ADD, 3'b010 for SUB, 3'b000 otherwise.
REQ-010 States SHALL be INIT(0), FETCH(1), DECODE(2), LOAD_A(3), LOAD_B(4), STORE(5), ADD(6), SUB(7), NOOP(8), HALT(9), encoded on State.
REQ-011 INIT SHALL go to FETCH unconditionally.
REQ-012 FETCH SHALL drive IR_rd=1, PC_addr=PC, and increment PC by 1 at the edge leaving FETCH; next state DECODE.
REQ-013 PC SHALL be 7 bits and wrap 127 -> 0 without flag or stall.
REQ-014 DECODE SHALL select the next state combinationally from IR_data[15:12] and load IR <= IR_data at the edge leaving DECODE.
REQ-015 LOAD_A SHALL drive D_addr=IR[11:4], RF_W_Addr=IR[3:0], MuxSel=1, RF_W_en=0; next LOAD_B (covers data-memory read latency).
REQ-016 LOAD_B SHALL drive the same as LOAD_A with RF_W_en=1; next FETCH.
REQ-017 STORE SHALL drive RF_A_addr=IR[11:8], D_addr=IR[7:0], D_wr=1 for exactly one cycle; next FETCH.
REQ-018 ADD/SUB SHALL drive RF_A_addr=IR[11:8], RF_B_addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s per REQ-009, MuxSel=0, RF_W_en=1 for exactly one cycle; next FETCH.
REQ-019 NOOP SHALL assert no write enable; next FETCH.
REQ-020 HALT SHALL hold Halted=1, IR_rd=0, PC frozen, all write enables 0, and remain in HALT until Reset.
REQ-021 Every output not explicitly driven in a state SHALL be 0 in that state; D_wr and RF_W_en SHALL never be high in the same cycle.
REQ-022 Cycle counts SHALL be: LOAD 4 cycles, STORE/ADD/SUB/NOOP 3 cycles, fetch-to-fetch.

Reset
REQ-023 Reset=1 at a rising edge SHALL force State=INIT, PC=0, IR=0 from the next cycle, regardless of current state including mid-LOAD or HALT.
REQ-024 In INIT and while Reset is held, all outputs SHALL be 0 (D_wr=0, RF_W_en=0, IR_rd=0, Halted=0).
REQ-025 The first FETCH SHALL occur in the cycle after the first edge with Reset=0, presenting PC_addr=0.

Verification
REQ-026 Reset then ROM[0]=16'h3123 (ADD) -> State 0,1,2,6; in ADD: RF_A_addr=1, RF_B_addr=2, RF_W_Addr=3, ALU_s=001, RF_W_en=1, MuxSel=0; PC_addr=1 at next FETCH.
REQ-027 ROM[0]=16'h11A5 (LOAD) -> LOAD_A then LOAD_B with D_addr=8'h1A, RF_W_Addr=5, MuxSel=1; RF_W_en high only in LOAD_B; next FETCH at cycle 5.
REQ-028 ROM[0]=16'h2740 (STORE) -> one cycle with D_wr=1, RF_A_addr=7, D_addr=8'h40, RF_W_en=0.
REQ-029 ROM[0..1]=16'hF000,16'h5000 -> opcode F runs as NOOP (no enables), then HALT: Halted=1, PC_addr stays 2 for 20 cycles; Reset -> INIT, PC=0.
REQ-030 ROM all NOOP, run 128 instructions -> PC_addr wraps 127 -> 0; Reset asserted during LOAD_A -> next cycle State=0 with RF_W_en never asserted.
